// File: rtl/cpu_pkg.sv
// Shared definitions for the 6502 core's interrupt entry logic.
//   - seq_state_e : interrupt sequencer state encoding
//   - int_src_e   : latched source of the running sequence
//   - PSR_*       : processor status bit indices
//   - *_DEF       : default vector addresses and stack page
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH_PCH,
    ST_PUSH_PCL,
    ST_PUSH_PSR,
    ST_VEC_L,
    ST_VEC_H,
    ST_LOAD_H
  } seq_state_e;

  typedef enum logic [1:0] {
    SRC_RESET,
    SRC_NMI,
    SRC_IRQ,
    SRC_BRK
  } int_src_e;

  localparam int unsigned PSR_C = 0;
  localparam int unsigned PSR_Z = 1;
  localparam int unsigned PSR_I = 2;
  localparam int unsigned PSR_D = 3;
  localparam int unsigned PSR_B = 4;
  localparam int unsigned PSR_U = 5;
  localparam int unsigned PSR_V = 6;
  localparam int unsigned PSR_N = 7;

  localparam logic [15:0] NMI_VECTOR_DEF   = 16'hFFFA;
  localparam logic [15:0] RESET_VECTOR_DEF = 16'hFFFC;
  localparam logic [15:0] IRQ_VECTOR_DEF   = 16'hFFFE;
  localparam logic [7:0]  STACK_PAGE_DEF   = 8'h01;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for an asynchronous active-low input.
//   clk, rst_x : clock and asynchronous active-low reset
//   async_i    : asynchronous input (idle high)
//   level_o    : synchronised level (resets to 1)
//   fall_o     : one-cycle pulse on a synchronised 1->0 transition
module edge_sync (
  input  logic clk,
  input  logic rst_x,
  input  logic async_i,
  output logic level_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       level_prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      sync_q       <= 2'b11;
      level_prev_q <= 1'b1;
    end else begin
      sync_q       <= {sync_q[0], async_i};
      level_prev_q <= sync_q[1];
    end
  end

  assign level_o = sync_q[1];
  assign fall_o  = level_prev_q & ~sync_q[1];

endmodule

// File: rtl/interrupt_sequencer.sv
// RESET / NMI / IRQ / BRK entry sequencer for the 6502 core.
// Pushes PCH, PCL and PSR, sets I, then loads PC from the vector pair.
// While busy it owns the memory bus and the exec controller stalls.
//   clk, rst_x          : clock, asynchronous active-low reset
//   nmi_x, irq_x        : external interrupts (NMI edge, IRQ level), active-low
//   exec_boundary/_brk  : preemption point from exec controller, BRK qualifier
//   busy, done          : sequence in progress / one-cycle completion pulse
//   mem_*               : memory bus (read data valid the cycle after mem_re)
//   intr_s/psr/pc       : live register-file values
//   intr_set_*, intr_data, intr_pushed : register-file update strobes
module interrupt_sequencer
  import cpu_pkg::*;
#(
  parameter logic [15:0] NMI_VECTOR   = NMI_VECTOR_DEF,
  parameter logic [15:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [15:0] IRQ_VECTOR   = IRQ_VECTOR_DEF,
  parameter logic [7:0]  STACK_PAGE   = STACK_PAGE_DEF
) (
  input  logic        clk,
  input  logic        rst_x,
  input  logic        nmi_x,
  input  logic        irq_x,
  input  logic        exec_boundary,
  input  logic        exec_brk,
  output logic        busy,
  output logic        done,
  output logic [15:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic [7:0]  intr_s,
  input  logic [7:0]  intr_psr,
  input  logic [15:0] intr_pc,
  output logic        intr_set_i,
  output logic        intr_set_b,
  output logic [7:0]  intr_data,
  output logic        intr_set_pcl,
  output logic        intr_set_pch,
  output logic        intr_pushed
);

  seq_state_e  state_q;
  int_src_e    src_q;
  logic        nmi_pend_q;
  logic        busy_q;
  logic        done_q;

  logic        nmi_fall;
  logic        nmi_level_unused;
  logic        irq_level;
  logic        irq_fall_unused;
  logic        irq_req;
  logic [15:0] vec_base;
  logic [7:0]  psr_push;

  edge_sync u_nmi_sync (
    .clk     (clk),
    .rst_x   (rst_x),
    .async_i (nmi_x),
    .level_o (nmi_level_unused),
    .fall_o  (nmi_fall)
  );

  edge_sync u_irq_sync (
    .clk     (clk),
    .rst_x   (rst_x),
    .async_i (irq_x),
    .level_o (irq_level),
    .fall_o  (irq_fall_unused)
  );

  assign irq_req = ~irq_level & ~intr_psr[PSR_I];

  // Reset lands directly in VEC_L with src=RESET, so the reset vector fetch
  // starts on the first cycle after rst_x releases.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q    <= ST_VEC_L;
      src_q      <= SRC_RESET;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      nmi_pend_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (exec_boundary) begin
            if (nmi_pend_q) begin
              state_q    <= ST_PUSH_PCH;
              src_q      <= SRC_NMI;
              busy_q     <= 1'b1;
              nmi_pend_q <= 1'b0;
            end else if (exec_brk) begin
              state_q <= ST_PUSH_PCH;
              src_q   <= SRC_BRK;
              busy_q  <= 1'b1;
            end else if (irq_req) begin
              state_q <= ST_PUSH_PCH;
              src_q   <= SRC_IRQ;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_PUSH_PCH: state_q <= ST_PUSH_PCL;
        ST_PUSH_PCL: state_q <= ST_PUSH_PSR;
        ST_PUSH_PSR: state_q <= ST_VEC_L;
        ST_VEC_L:    state_q <= ST_VEC_H;
        ST_VEC_H:    state_q <= ST_LOAD_H;
        ST_LOAD_H: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      // A fresh edge wins over the clear, so an edge coinciding with the
      // accept of an earlier NMI is not lost.
      if (nmi_fall) nmi_pend_q <= 1'b1;
    end
  end

  always_comb begin
    case (src_q)
      SRC_NMI:   vec_base = NMI_VECTOR;
      SRC_RESET: vec_base = RESET_VECTOR;
      default:   vec_base = IRQ_VECTOR;
    endcase
  end

  always_comb begin
    psr_push        = intr_psr;
    psr_push[PSR_U] = 1'b1;
    psr_push[PSR_B] = (src_q == SRC_BRK);
  end

  // Bus and register-file strobes are decoded from the state rather than
  // registered: the stack address must follow SP as the register file
  // decrements it, and intr_data forwards mem_rdata in the same cycle.
  // They are forced to zero while rst_x is held.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    mem_addr     = 16'h0000;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_wdata    = 8'h00;
    intr_set_i   = 1'b0;
    intr_set_b   = 1'b0;
    intr_data    = 8'h00;
    intr_set_pcl = 1'b0;
    intr_set_pch = 1'b0;
    intr_pushed  = 1'b0;
    if (rst_x) begin
      case (state_q)
        ST_PUSH_PCH: begin
          mem_we      = 1'b1;
          mem_addr    = {STACK_PAGE, intr_s};
          mem_wdata   = intr_pc[15:8];
          intr_pushed = 1'b1;
        end
        ST_PUSH_PCL: begin
          mem_we      = 1'b1;
          mem_addr    = {STACK_PAGE, intr_s};
          mem_wdata   = intr_pc[7:0];
          intr_pushed = 1'b1;
        end
        ST_PUSH_PSR: begin
          mem_we      = 1'b1;
          mem_addr    = {STACK_PAGE, intr_s};
          mem_wdata   = psr_push;
          intr_pushed = 1'b1;
          intr_set_b  = (src_q == SRC_BRK);
        end
        ST_VEC_L: begin
          mem_re     = 1'b1;
          mem_addr   = vec_base;
          intr_set_i = 1'b1;
        end
        ST_VEC_H: begin
          mem_re       = 1'b1;
          mem_addr     = vec_base + 16'd1;
          intr_set_pcl = 1'b1;
          intr_data    = mem_rdata;
        end
        ST_LOAD_H: begin
          intr_set_pch = 1'b1;
          intr_data    = mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer. A small register-file and memory
// model reacts to the DUT strobes; each scenario task checks its results
// against hand-computed values.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst_x = 1'b0;
  logic        nmi_x = 1'b1;
  logic        irq_x = 1'b1;
  logic        exec_boundary = 1'b0;
  logic        exec_brk = 1'b0;
  logic        busy, done, mem_re, mem_we;
  logic        intr_set_i, intr_set_b, intr_set_pcl, intr_set_pch, intr_pushed;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, intr_data;
  logic [7:0]  mem_rdata = 8'hEE;
  logic [7:0]  sp = 8'hFF;
  logic [7:0]  psr = 8'h00;
  logic [15:0] pc = 16'h0000;

  logic [7:0]  mem [0:65535];
  logic [15:0] wr_a[$];
  logic [7:0]  wr_d[$];
  logic [15:0] rd_a[$];
  int          setb_n, seti_n;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  interrupt_sequencer dut (
    .clk           (clk),
    .rst_x         (rst_x),
    .nmi_x         (nmi_x),
    .irq_x         (irq_x),
    .exec_boundary (exec_boundary),
    .exec_brk      (exec_brk),
    .busy          (busy),
    .done          (done),
    .mem_addr      (mem_addr),
    .mem_re        (mem_re),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .intr_s        (sp),
    .intr_psr      (psr),
    .intr_pc       (pc),
    .intr_set_i    (intr_set_i),
    .intr_set_b    (intr_set_b),
    .intr_data     (intr_data),
    .intr_set_pcl  (intr_set_pcl),
    .intr_set_pch  (intr_set_pch),
    .intr_pushed   (intr_pushed)
  );

  // One clock cycle: sample strobes before the edge, update the memory and
  // register-file model just after it, return on the following negedge.
  task automatic step();
    logic        we_s, re_s, pu_s, si_s, sb_s, pl_s, ph_s;
    logic [15:0] a_s;
    logic [7:0]  wd_s, d_s;
    #1;
    we_s = mem_we;  re_s = mem_re;  pu_s = intr_pushed;
    si_s = intr_set_i;  sb_s = intr_set_b;
    pl_s = intr_set_pcl;  ph_s = intr_set_pch;
    a_s = mem_addr;  wd_s = mem_wdata;  d_s = intr_data;
    checks++;
    if (we_s && re_s) begin
      failures++;
      $display("FAIL strobe_excl: mem_re=%b mem_we=%b, required at most one high", re_s, we_s);
    end
    if (we_s) begin wr_a.push_back(a_s); wr_d.push_back(wd_s); end
    if (re_s) rd_a.push_back(a_s);
    if (sb_s) setb_n++;
    if (si_s) seti_n++;
    @(posedge clk);
    #1;
    if (we_s) mem[a_s] = wd_s;
    mem_rdata = re_s ? mem[a_s] : 8'hEE;
    if (pu_s) sp = sp - 8'd1;
    if (pl_s) pc[7:0] = d_s;
    if (ph_s) pc[15:8] = d_s;
    if (si_s) psr[2] = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_logs();
    wr_a.delete(); wr_d.delete(); rd_a.delete();
    setb_n = 0; seti_n = 0;
  endtask

  // {count, addr0, data0, addr1, data1, addr2, data2}
  function automatic logic [79:0] pack_writes();
    logic [79:0] p;
    p = '0;
    p[79:72] = 8'(wr_a.size());
    for (int i = 0; i < 3 && i < wr_a.size(); i++)
      p[71 - 24*i -: 24] = {wr_a[i], wr_d[i]};
    return p;
  endfunction

  // {count, addr0, addr1}
  function automatic logic [39:0] pack_reads();
    logic [39:0] p;
    p = '0;
    p[39:32] = 8'(rd_a.size());
    for (int i = 0; i < 2 && i < rd_a.size(); i++)
      p[31 - 16*i -: 16] = rd_a[i];
    return p;
  endfunction

  // Step until done is seen, counting busy cycles; bounded by budget.
  task automatic run_seq(input int budget, output int nbusy, output bit got_done);
    nbusy = 0;
    got_done = 1'b0;
    for (int i = 0; i < budget && !got_done; i++) begin
      if (done) got_done = 1'b1;
      else begin
        if (busy) nbusy++;
        step();
      end
    end
  endtask

  task automatic accept_pulse(input logic brk);
    exec_brk = brk;
    exec_boundary = 1'b1;
    step();
    exec_boundary = 1'b0;
    exec_brk = 1'b0;
  endtask

  task automatic test_reset();
    int nb; bit gd;
    rst_x = 1'b0;
    clear_logs();
    repeat (2) step();
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_busy: got %b want 1", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b want 0", done); end
    checks++;
    if ({mem_re, mem_we, intr_set_i, intr_set_b, intr_set_pcl, intr_set_pch, intr_pushed} !== 7'b0) begin
      failures++; $display("FAIL rst_strobes: re=%b we=%b set_i=%b pushed=%b, want all 0",
                           mem_re, mem_we, intr_set_i, intr_pushed);
    end
    checks++;
    if ({mem_addr, mem_wdata, intr_data} !== 32'h0) begin
      failures++; $display("FAIL rst_bus: addr=%h wdata=%h data=%h, want 0", mem_addr, mem_wdata, intr_data);
    end
    rst_x = 1'b1;
    #1;
    checks++;
    if ({mem_re, mem_addr, intr_set_i} !== {1'b1, 16'hFFFC, 1'b1}) begin
      failures++; $display("FAIL rst_vec_l: re=%b addr=%h set_i=%b, want 1 FFFC 1", mem_re, mem_addr, intr_set_i);
    end
    run_seq(20, nb, gd);
    checks++; if (!gd) begin failures++; $display("FAIL rst_timeout: done not seen within 20 cycles"); end
    checks++; if (nb != 3) begin failures++; $display("FAIL rst_latency: got %0d busy cycles want 3", nb); end
    checks++;
    if (pack_reads() !== {8'd2, 16'hFFFC, 16'hFFFD}) begin
      failures++; $display("FAIL rst_reads: got %h want 02FFFCFFFD", pack_reads());
    end
    checks++; if (wr_a.size() != 0) begin failures++; $display("FAIL rst_no_write: got %0d writes want 0", wr_a.size()); end
    checks++; if (pc !== 16'h1234) begin failures++; $display("FAIL rst_pc: got %h want 1234", pc); end
    step();
    checks++;
    if ({done, busy} !== 2'b00) begin
      failures++; $display("FAIL rst_done_pulse: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_irq();
    int nb; bit gd;
    pc = 16'hC123; sp = 8'hFD; psr = 8'h00;
    irq_x = 1'b0;
    repeat (3) step();
    clear_logs();
    accept_pulse(1'b0);
    run_seq(20, nb, gd);
    checks++; if (!gd) begin failures++; $display("FAIL irq_timeout: done not seen"); end
    checks++; if (nb != 6) begin failures++; $display("FAIL irq_latency: got %0d busy cycles want 6", nb); end
    checks++;
    if (pack_writes() !== {8'd3, 16'h01FD, 8'hC1, 16'h01FC, 8'h23, 16'h01FB, 8'h20}) begin
      failures++; $display("FAIL irq_pushes: got %h want 0301FDC101FC2301FB20", pack_writes());
    end
    checks++;
    if (pack_reads() !== {8'd2, 16'hFFFE, 16'hFFFF}) begin
      failures++; $display("FAIL irq_reads: got %h want 02FFFEFFFF", pack_reads());
    end
    checks++;
    if ({sp, pc, psr[2], 8'(setb_n)} !== {8'hFA, 16'h5678, 1'b1, 8'd0}) begin
      failures++; $display("FAIL irq_regs: sp=%h pc=%h I=%b setb=%0d, want FA 5678 1 0", sp, pc, psr[2], setb_n);
    end
    irq_x = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_masked_irq();
    psr = 8'h04;
    irq_x = 1'b0;
    repeat (3) step();
    clear_logs();
    accept_pulse(1'b0);
    #1;
    checks++;
    if ({busy, mem_re, mem_we} !== 3'b000) begin
      failures++; $display("FAIL masked_idle: busy=%b re=%b we=%b, want 0 0 0", busy, mem_re, mem_we);
    end
    repeat (3) step();
    checks++;
    if ({busy, 8'(wr_a.size()), 8'(rd_a.size())} !== 17'h0) begin
      failures++; $display("FAIL masked_no_seq: busy=%b writes=%0d reads=%0d, want 0", busy, wr_a.size(), rd_a.size());
    end
    irq_x = 1'b1;
    repeat (3) step();
  endtask

  // BRK with SP=01 also exercises the in-page stack wrap 0100 -> 01FF.
  task automatic test_brk();
    int nb; bit gd;
    pc = 16'h3456; sp = 8'h01; psr = 8'hC3;
    clear_logs();
    accept_pulse(1'b1);
    run_seq(20, nb, gd);
    checks++; if (!gd || nb != 6) begin failures++; $display("FAIL brk_latency: done=%b busy cycles=%0d, want 1 6", gd, nb); end
    checks++;
    if (pack_writes() !== {8'd3, 16'h0101, 8'h34, 16'h0100, 8'h56, 16'h01FF, 8'hF3}) begin
      failures++; $display("FAIL brk_pushes: got %h want 030101340100560 1FFF3", pack_writes());
    end
    checks++; if (setb_n != 1) begin failures++; $display("FAIL brk_set_b: got %0d pulses want 1", setb_n); end
    checks++;
    if ({pack_reads(), sp, pc} !== {8'd2, 16'hFFFE, 16'hFFFF, 8'hFE, 16'h5678}) begin
      failures++; $display("FAIL brk_vec: reads=%h sp=%h pc=%h, want 02FFFEFFFF FE 5678", pack_reads(), sp, pc);
    end
  endtask

  task automatic test_nmi_vs_irq();
    int nb; bit gd;
    pc = 16'h4455; sp = 8'hF0; psr = 8'h00;
    irq_x = 1'b0;
    nmi_x = 1'b0;
    repeat (4) step();
    clear_logs();
    accept_pulse(1'b0);
    run_seq(20, nb, gd);
    checks++;
    if ({gd, pack_reads()} !== {1'b1, 8'd2, 16'hFFFA, 16'hFFFB}) begin
      failures++; $display("FAIL nmi_first: done=%b reads=%h, want 1 02FFFAFFFB", gd, pack_reads());
    end
    checks++;
    if (pack_writes() !== {8'd3, 16'h01F0, 8'h44, 16'h01EF, 8'h55, 16'h01EE, 8'h20}) begin
      failures++; $display("FAIL nmi_pushes: got %h want 0301F04401EF5501EE20", pack_writes());
    end
    checks++; if (pc !== 16'h9ABC) begin failures++; $display("FAIL nmi_pc: got %h want 9ABC", pc); end
    clear_logs();
    accept_pulse(1'b0);
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL irq_masked_after_nmi: busy=%b want 0", busy); end
    psr[2] = 1'b0;
    step();
    accept_pulse(1'b0);
    run_seq(20, nb, gd);
    checks++;
    if ({gd, pack_reads(), pc} !== {1'b1, 8'd2, 16'hFFFE, 16'hFFFF, 16'h5678}) begin
      failures++; $display("FAIL irq_after_nmi: done=%b reads=%h pc=%h, want 1 02FFFEFFFF 5678", gd, pack_reads(), pc);
    end
    irq_x = 1'b1;
    nmi_x = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_nmi_during_irq();
    int nb; bit gd;
    pc = 16'h1111; sp = 8'h80; psr = 8'h00;
    irq_x = 1'b0;
    repeat (3) step();
    clear_logs();
    accept_pulse(1'b0);
    nmi_x = 1'b0;
    irq_x = 1'b1;
    step();
    exec_boundary = 1'b1;
    step();
    exec_boundary = 1'b0;
    run_seq(20, nb, gd);
    checks++;
    if ({gd, 8'(nb)} !== {1'b1, 8'd4}) begin
      failures++; $display("FAIL irq_not_aborted: done=%b remaining busy=%0d, want 1 4", gd, nb);
    end
    checks++;
    if (pack_writes() !== {8'd3, 16'h0180, 8'h11, 16'h017F, 8'h11, 16'h017E, 8'h20}) begin
      failures++; $display("FAIL irq_nmi_pushes: got %h want 03018011017F11017E20", pack_writes());
    end
    clear_logs();
    accept_pulse(1'b0);
    run_seq(20, nb, gd);
    checks++;
    if ({gd, pack_reads(), pc} !== {1'b1, 8'd2, 16'hFFFA, 16'hFFFB, 16'h9ABC}) begin
      failures++; $display("FAIL nmi_pending: done=%b reads=%h pc=%h, want 1 02FFFAFFFB 9ABC", gd, pack_reads(), pc);
    end
    accept_pulse(1'b0);
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL nmi_pend_cleared: busy=%b want 0", busy); end
    nmi_x = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_reset_abort();
    int nb; bit gd;
    pc = 16'hABCD; sp = 8'h50; psr = 8'h00;
    irq_x = 1'b0;
    repeat (3) step();
    clear_logs();
    accept_pulse(1'b0);
    step();
    #1;
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h014F, 8'hCD}) begin
      failures++; $display("FAIL push_pcl: we=%b addr=%h wdata=%h, want 1 014F CD", mem_we, mem_addr, mem_wdata);
    end
    rst_x = 1'b0;
    irq_x = 1'b1;
    #1;
    checks++;
    if ({busy, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0000}) begin
      failures++; $display("FAIL abort_outputs: busy=%b we=%b addr=%h, want 1 0 0000", busy, mem_we, mem_addr);
    end
    step();
    checks++;
    if (pack_writes() !== {8'd1, 16'h0150, 8'hAB, 48'h0}) begin
      failures++; $display("FAIL abort_partial: got %h want 010150AB000000000000", pack_writes());
    end
    rst_x = 1'b1;
    #1;
    checks++;
    if ({mem_re, mem_addr} !== {1'b1, 16'hFFFC}) begin
      failures++; $display("FAIL abort_vec_l: re=%b addr=%h, want 1 FFFC", mem_re, mem_addr);
    end
    clear_logs();
    run_seq(20, nb, gd);
    checks++;
    if ({gd, 8'(nb), pack_reads(), pc, 8'(wr_a.size())} !==
        {1'b1, 8'd3, 8'd2, 16'hFFFC, 16'hFFFD, 16'h1234, 8'd0}) begin
      failures++; $display("FAIL abort_reset_seq: done=%b busy=%0d reads=%h pc=%h writes=%0d, want 1 3 02FFFCFFFD 1234 0",
                           gd, nb, pack_reads(), pc, wr_a.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFA] = 8'hBC; mem[16'hFFFB] = 8'h9A;
    mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
    mem[16'hFFFE] = 8'h78; mem[16'hFFFF] = 8'h56;
    @(negedge clk);
    test_reset();
    test_irq();
    test_masked_irq();
    test_brk();
    test_nmi_vs_irq();
    test_nmi_during_irq();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
